// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage.
//   - Default data and register-index widths.
//   - NZCV bit positions within the 4-bit status word.
//   - Writeback FSM state encoding.
package writeback_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_W  = 4;
  localparam int unsigned STATUS_W  = 4;
  localparam int unsigned CNT_W     = 32;

  // NZCV flag bit positions
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage : writeback_pkg

// File: rtl/writeback_status_register.sv
// Load-enabled NZCV flag register.
//   clk  : clock
//   rst  : synchronous active-low reset (clears the flags)
//   ld_i : load enable
//   d_i  : new flag value
//   q_o  : registered flags
module status_register
  import writeback_pkg::*;
#(
  parameter int unsigned W = STATUS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] flags_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (ld_i) begin
      flags_q <= d_i;
    end
  end

  assign q_o = flags_q;

endmodule : status_register

// File: rtl/writeback_unit.sv
// Writeback stage: retires MEM-stage instructions into the register file,
// waiting for late load data when necessary.
//   clk, rst                  : clock, synchronous active-low reset
//   freeze, flush             : hazard-unit hold / branch-taken discard
//   in_valid, in_pc, in_alu_result, in_dest, in_status,
//   in_wb_en, in_mem_read, in_s : MEM-stage instruction payload
//   mem_rdata, mem_ready      : load data and its valid
//   wb_enable, wb_dest, wb_value : register-file write port (registered)
//   status                    : NZCV flags (registered)
//   pc_out                    : PC of last retired instruction (registered)
//   stall_req                 : high while waiting on load data (from state)
//   retired_count             : free-running retired-instruction counter
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned REG_W  = WB_REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [DATA_W-1:0]   in_alu_result,
  input  logic [REG_W-1:0]    in_dest,
  input  logic [STATUS_W-1:0] in_status,
  input  logic                in_wb_en,
  input  logic                in_mem_read,
  input  logic                in_s,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                wb_enable,
  output logic [REG_W-1:0]    wb_dest,
  output logic [DATA_W-1:0]   wb_value,
  output logic [STATUS_W-1:0] status,
  output logic [DATA_W-1:0]   pc_out,
  output logic                stall_req,
  output logic [CNT_W-1:0]    retired_count
);

  wb_state_e           state_q,     state_d;
  logic                wb_en_q,     wb_en_d;
  logic [REG_W-1:0]    wb_dest_q,   wb_dest_d;
  logic [DATA_W-1:0]   wb_value_q,  wb_value_d;
  logic [DATA_W-1:0]   pc_q,        pc_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  // Payload of a load parked in WAIT_MEM
  logic                lat_wb_en_q,  lat_wb_en_d;
  logic [REG_W-1:0]    lat_dest_q,   lat_dest_d;
  logic [DATA_W-1:0]   lat_pc_q,     lat_pc_d;
  logic                lat_s_q,      lat_s_d;
  logic [STATUS_W-1:0] lat_status_q, lat_status_d;

  logic                status_ld;
  logic [STATUS_W-1:0] status_nxt;
  logic                accept;

  assign accept = (state_q == RUN) && in_valid && !freeze && !flush;

  // Next-state and datapath selection
  always_comb begin
    state_d      = state_q;
    wb_en_d      = 1'b0;
    wb_dest_d    = wb_dest_q;
    wb_value_d   = wb_value_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    lat_wb_en_d  = lat_wb_en_q;
    lat_dest_d   = lat_dest_q;
    lat_pc_d     = lat_pc_q;
    lat_s_d      = lat_s_q;
    lat_status_d = lat_status_q;
    status_ld    = 1'b0;
    status_nxt   = in_status;

    if (flush) begin
      // Discard any in-flight or parked instruction
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            if (in_mem_read && !mem_ready) begin
              lat_wb_en_d  = in_wb_en;
              lat_dest_d   = in_dest;
              lat_pc_d     = in_pc;
              lat_s_d      = in_s;
              lat_status_d = in_status;
              state_d      = WAIT_MEM;
            end else begin
              wb_en_d    = in_wb_en;
              wb_dest_d  = in_dest;
              wb_value_d = in_mem_read ? mem_rdata : in_alu_result;
              pc_d       = in_pc;
              cnt_d      = cnt_q + CNT_W'(1);
              status_ld  = in_s;
              status_nxt = in_status;
            end
          end
        end
        WAIT_MEM: begin
          // freeze is intentionally ignored while waiting on load data
          if (mem_ready) begin
            wb_en_d    = lat_wb_en_q;
            wb_dest_d  = lat_dest_q;
            wb_value_d = mem_rdata;
            pc_d       = lat_pc_q;
            cnt_d      = cnt_q + CNT_W'(1);
            status_ld  = lat_s_q;
            status_nxt = lat_status_q;
            state_d    = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= '0;
      wb_value_q   <= '0;
      pc_q         <= '0;
      cnt_q        <= '0;
      lat_wb_en_q  <= 1'b0;
      lat_dest_q   <= '0;
      lat_pc_q     <= '0;
      lat_s_q      <= 1'b0;
      lat_status_q <= '0;
    end else begin
      state_q      <= state_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
      wb_value_q   <= wb_value_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      lat_wb_en_q  <= lat_wb_en_d;
      lat_dest_q   <= lat_dest_d;
      lat_pc_q     <= lat_pc_d;
      lat_s_q      <= lat_s_d;
      lat_status_q <= lat_status_d;
    end
  end

  status_register #(.W(STATUS_W)) u_status (
    .clk  (clk),
    .rst  (rst),
    .ld_i (status_ld),
    .d_i  (status_nxt),
    .q_o  (status)
  );

  assign wb_enable     = wb_en_q;
  assign wb_dest       = wb_dest_q;
  assign wb_value      = wb_value_q;
  assign pc_out        = pc_q;
  assign retired_count = cnt_q;
  assign stall_req     = (state_q == WAIT_MEM);

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_writeback_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  logic          clk;
  logic          rst;
  logic          freeze, flush, in_valid;
  logic [DW-1:0] in_pc, in_alu_result, mem_rdata;
  logic [RW-1:0] in_dest;
  logic [3:0]    in_status;
  logic          in_wb_en, in_mem_read, in_s, mem_ready;
  logic          wb_enable;
  logic [RW-1:0] wb_dest;
  logic [DW-1:0] wb_value, pc_out;
  logic [3:0]    status;
  logic          stall_req;
  logic [31:0]   retired_count;

  writeback_unit #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_alu_result (in_alu_result),
    .in_dest       (in_dest),
    .in_status     (in_status),
    .in_wb_en      (in_wb_en),
    .in_mem_read   (in_mem_read),
    .in_s          (in_s),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .wb_enable     (wb_enable),
    .wb_dest       (wb_dest),
    .wb_value      (wb_value),
    .status        (status),
    .pc_out        (pc_out),
    .stall_req     (stall_req),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an instruction that has been accepted but whose load data is pending
  typedef struct {
    logic          wb_en;
    logic [RW-1:0] dest;
    logic [DW-1:0] pc;
    logic          s;
    logic [3:0]    st;
  } op_t;

  op_t           pend[$];
  logic          m_en;
  logic [RW-1:0] m_dest;
  logic [DW-1:0] m_val, m_pc;
  logic [3:0]    m_stat;
  logic [31:0]   m_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int writes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic retire(input op_t op, input logic [DW-1:0] value);
    m_en   = op.wb_en;
    m_dest = op.dest;
    m_val  = value;
    m_pc   = op.pc;
    m_cnt  = m_cnt + 32'd1;
    if (op.s) m_stat = op.st;
  endtask

  // One clock edge of architectural behaviour from the current inputs
  task automatic model_edge();
    op_t cur;
    cur.wb_en = in_wb_en; cur.dest = in_dest; cur.pc = in_pc;
    cur.s = in_s; cur.st = in_status;
    m_en = 1'b0;
    if (!rst) begin
      pend.delete();
      m_dest = '0; m_val = '0; m_pc = '0; m_stat = '0; m_cnt = '0;
    end else if (flush) begin
      pend.delete();
    end else if (pend.size() != 0) begin
      if (mem_ready) retire(pend.pop_front(), mem_rdata);
    end else if (in_valid && !freeze) begin
      if (in_mem_read && !mem_ready) pend.push_back(cur);
      else retire(cur, in_mem_read ? mem_rdata : in_alu_result);
    end
  endtask

  task automatic check_all();
    chk("wb_enable", 32'(wb_enable), 32'(m_en));
    chk("wb_dest",   32'(wb_dest),   32'(m_dest));
    chk("wb_value",  wb_value,       m_val);
    chk("pc_out",    pc_out,         m_pc);
    chk("status",    32'(status),    32'(m_stat));
    chk("stall_req", 32'(stall_req), 32'(pend.size() != 0));
    chk("retired",   retired_count,  m_cnt);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    if (wb_enable) writes++;
    check_all();
  endtask

  task automatic idle();
    freeze = 0; flush = 0; in_valid = 0; in_mem_read = 0; in_wb_en = 0;
    in_s = 0; mem_ready = 0;
  endtask

  initial begin
    rst = 0; idle();
    in_pc = '0; in_alu_result = '0; mem_rdata = '0; in_dest = '0; in_status = '0;
    m_en = 0; m_dest = '0; m_val = '0; m_pc = '0; m_stat = '0; m_cnt = '0;
    writes = 0;
    #2;
    cycle(); cycle();
    chk("reset_cnt", retired_count, 32'd0);
    rst = 1;

    // ALU op retires one edge after accept
    in_valid = 1; in_wb_en = 1; in_dest = 4'd5; in_alu_result = 32'h0000_002A;
    in_pc = 32'h0000_0100;
    cycle();
    chk("alu_en",   32'(wb_enable), 32'd1);
    chk("alu_dest", 32'(wb_dest),   32'd5);
    chk("alu_val",  wb_value,       32'h2A);
    chk("alu_cnt",  retired_count,  32'd1);
    idle(); cycle();
    chk("alu_pulse", 32'(wb_enable), 32'd0);

    // Late load: three stall cycles then a single write
    in_valid = 1; in_mem_read = 1; in_wb_en = 1; in_dest = 4'd9; in_pc = 32'h104;
    cycle();
    chk("load_stall0", 32'(stall_req), 32'd1);
    idle(); cycle(); cycle();
    chk("load_stall2", 32'(stall_req), 32'd1);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; cycle();
    chk("load_en",    32'(wb_enable), 32'd1);
    chk("load_val",   wb_value,       32'hDEAD_BEEF);
    chk("load_stall", 32'(stall_req), 32'd0);
    idle(); cycle();
    chk("load_pulse", 32'(wb_enable), 32'd0);

    // Status updates only with S set
    in_valid = 1; in_s = 1; in_status = 4'b0110; in_wb_en = 1; cycle();
    chk("status_set", 32'(status), 32'b0110);
    in_s = 0; in_status = 4'b1111; cycle();
    chk("status_hold", 32'(status), 32'b0110);
    idle(); cycle();

    // Flush while waiting on a load abandons it
    in_valid = 1; in_mem_read = 1; in_wb_en = 1; cycle();
    idle(); flush = 1; mem_ready = 1; mem_rdata = 32'h1234_5678; cycle();
    chk("flush_en",    32'(wb_enable), 32'd0);
    chk("flush_cnt",   retired_count,  32'd4);
    chk("flush_stall", 32'(stall_req), 32'd0);
    idle(); cycle();

    // Freeze holds the instruction; release gives exactly one write
    writes = 0;
    in_valid = 1; in_wb_en = 1; freeze = 1; in_alu_result = 32'h77; cycle(); cycle();
    chk("freeze_writes", 32'(writes), 32'd0);
    freeze = 0; cycle();
    idle(); cycle();
    chk("unfreeze_writes", 32'(writes), 32'd1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 39) != 0);
      freeze        = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      in_mem_read   = ($urandom_range(0, 9) < 4);
      mem_ready     = ($urandom_range(0, 1) == 1);
      in_wb_en      = ($urandom_range(0, 3) != 0);
      in_s          = ($urandom_range(0, 1) == 1);
      in_pc         = $urandom;
      in_alu_result = $urandom;
      mem_rdata     = $urandom;
      in_dest       = RW'($urandom_range(0, 15));
      in_status     = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1; idle(); cycle();

    // Counter wraps from all-ones to zero
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    in_valid = 1; in_wb_en = 1; cycle();
    chk("wrap_cnt", retired_count, 32'd0);
    idle(); cycle();

    // Reset during WAIT_MEM clears everything without a write
    in_valid = 1; in_mem_read = 1; in_wb_en = 1; in_s = 1; in_status = 4'b1010; cycle();
    idle(); rst = 0; mem_ready = 1; cycle();
    chk("rst_en",    32'(wb_enable), 32'd0);
    chk("rst_val",   wb_value,       32'd0);
    chk("rst_stat",  32'(status),    32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_cnt",   retired_count,  32'd0);
    rst = 1; idle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_writeback_unit
